// File: rtl/fetch_pkg.sv
// Shared constants and types for the prefetching instruction fetch unit.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] RESET_VEC_DEF = 32'hBFC0_0000;
  localparam logic [FETCH_XLEN-1:0] EXC_VEC_DEF   = 32'h8000_0080;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {SEQ, EXC, BR, JMP} redir_sel_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr] <= din;
  end

  assign dout  = r_mem[r_rd];
  assign count = r_cnt;
  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == CW'(DEPTH));

endmodule

// File: rtl/fetch_pq.sv
// Instruction fetch with PC register, prioritised redirect, pipelined imem requests
// and a prefetch queue to decode; stale responses after a redirect are counted and dropped.
module fetch_pq
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN      = 32,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [XLEN-1:0]  RESET_VEC = RESET_VEC_DEF,
  parameter logic [XLEN-1:0]  EXC_VEC   = EXC_VEC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             except,
  input  logic             br,
  input  logic [XLEN-1:0]  sign,
  input  logic             jmp,
  input  logic [XLEN-1:0]  fixed,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned DW = 16;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0]   r_pc;
  logic [DW-1:0]     r_drop;
  logic [DW-1:0]     w_drop_next;
  logic [DW-1:0]     w_drop_sum;
  redir_sel_e        w_sel;
  logic              w_redirect;
  logic [XLEN-1:0]   w_target_raw;
  logic [XLEN-1:0]   w_target;
  logic              w_credit;
  logic              w_accept;
  logic              w_rsp_keep;
  logic              w_deq;
  logic [XLEN-1:0]   w_pcq_head;
  logic [CW-1:0]     w_pcq_cnt;
  logic              w_pcq_empty;
  logic              w_pcq_full;
  logic [2*XLEN-1:0] w_ifq_din;
  logic [2*XLEN-1:0] w_ifq_dout;
  logic [CW-1:0]     w_ifq_cnt;
  logic              w_ifq_empty;
  logic              w_ifq_full;
  logic [XLEN-1:0]   w_head_pc;
  logic [XLEN-1:0]   w_head_instr;

  always_comb begin
    w_sel        = SEQ;
    w_target_raw = r_pc;
    if (except) begin
      w_sel        = EXC;
      w_target_raw = EXC_VEC;
    end else if (br) begin
      w_sel        = BR;
      w_target_raw = sign;
    end else if (jmp) begin
      w_sel        = JMP;
      w_target_raw = fixed;
    end
  end

  assign w_redirect = (w_sel != SEQ);
  assign w_target   = {w_target_raw[XLEN-1:2], 2'b00};

  // Credit covers both requests in flight and entries waiting for decode.
  assign w_credit = !w_pcq_full && !w_ifq_full &&
                    (({1'b0, w_pcq_cnt} + {1'b0, w_ifq_cnt}) < DEPTH_C);
  assign imem_req   = !rst && !w_redirect && w_credit;
  assign imem_addr  = r_pc;
  assign w_accept   = imem_req && imem_gnt;
  assign w_rsp_keep = imem_rvalid && !w_redirect && (r_drop == '0) && !w_pcq_empty;
  assign w_deq      = out_valid && out_ready && !w_redirect;

  always_ff @(posedge clk) begin
    if (rst)             r_pc <= RESET_VEC;
    else if (w_redirect) r_pc <= w_target;
    else if (w_accept)   r_pc <= r_pc + XLEN'(4);
  end

  // A response arriving in the redirect cycle is itself one of the stale ones.
  always_comb begin
    w_drop_sum  = r_drop + DW'(w_pcq_cnt);
    w_drop_next = r_drop;
    if (w_redirect) begin
      w_drop_next = (imem_rvalid && (w_drop_sum != '0)) ? w_drop_sum - DW'(1) : w_drop_sum;
    end else if (imem_rvalid && (r_drop != '0)) begin
      w_drop_next = r_drop - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_drop <= '0;
    else     r_drop <= w_drop_next;
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pcq (
    .clk   (clk),
    .rst   (rst),
    .push  (w_accept),
    .pop   (w_rsp_keep),
    .flush (w_redirect),
    .din   (r_pc),
    .dout  (w_pcq_head),
    .count (w_pcq_cnt),
    .empty (w_pcq_empty),
    .full  (w_pcq_full)
  );

  assign w_ifq_din = {w_pcq_head, imem_rdata};

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_ifq (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rsp_keep),
    .pop   (w_deq),
    .flush (w_redirect),
    .din   (w_ifq_din),
    .dout  (w_ifq_dout),
    .count (w_ifq_cnt),
    .empty (w_ifq_empty),
    .full  (w_ifq_full)
  );

  assign {w_head_pc, w_head_instr} = w_ifq_dout;
  assign out_valid = !w_ifq_empty;
  assign out_pc    = w_ifq_empty ? '0 : w_head_pc;
  assign out_instr = w_ifq_empty ? '0 : w_head_instr;

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> ((r_drop != '0) || !w_pcq_empty));

endmodule

// File: tb/tb_fetch_pq.sv
// Directed bench for fetch_pq with a latency-programmable in-order memory model.
module tb_fetch_pq;

  localparam logic [31:0] BASE = 32'hBFC0_0000;
  localparam logic [31:0] EXCV = 32'h8000_0080;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        except = 1'b0;
  logic        br = 1'b0;
  logic        jmp = 1'b0;
  logic [31:0] sign = '0;
  logic [31:0] fixed = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int n_acc = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  fetch_pq #(.XLEN(32), .DEPTH(4), .RESET_VEC(32'hBFC0_0000), .EXC_VEC(32'h8000_0080)) dut (
    .clk(clk), .rst(rst), .except(except), .br(br), .sign(sign), .jmp(jmp), .fixed(fixed),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Memory: accepts on req&&gnt, answers in order no earlier than lat edges later.
  always @(posedge clk) begin
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      n_acc = 0;
    end else begin
      if (imem_rvalid && mq_addr.size() > 0) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req && imem_gnt) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + lat);
        n_acc++;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!rst && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input logic rdy);
    rst = 1'b1; except = 1'b0; br = 1'b0; jmp = 1'b0;
    out_ready = rdy; lat = l;
    repeat (2) tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected 0", out_instr); end
  endtask

  task automatic test_seq();
    logic [31:0] e;
    do_reset(1, 1'b1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== BASE) begin failures++; $display("FAIL seq_first: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, BASE); end
    for (int k = 0; k < 6; k++) begin
      tick();
      e = BASE + 32'(4 * (k + 1));
      checks++; if (imem_req !== 1'b1 || imem_addr !== e) begin failures++; $display("FAIL seq_addr[%0d]: got req=%b addr=%h expected 1 %h", k, imem_req, imem_addr, e); end
      if (k >= 1) begin
        e = BASE + 32'(4 * (k - 1));
        checks++; if (out_valid !== 1'b1 || out_pc !== e || out_instr !== mem_word(e)) begin failures++; $display("FAIL seq_out[%0d]: got v=%b pc=%h i=%h expected 1 %h %h", k, out_valid, out_pc, out_instr, e, mem_word(e)); end
      end
    end
  endtask

  task automatic test_priority();
    sign = 32'h0000_0100; fixed = 32'h0000_0200;
    except = 1'b1; br = 1'b1; jmp = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL prio_req_held: got %b expected 0", imem_req); end
    tick(); except = 1'b0; #1;
    checks++; if (imem_addr !== EXCV) begin failures++; $display("FAIL prio_exc: got %h expected %h", imem_addr, EXCV); end
    tick(); br = 1'b0; #1;
    checks++; if (imem_addr !== 32'h0000_0100) begin failures++; $display("FAIL prio_br: got %h expected 00000100", imem_addr); end
    tick(); jmp = 1'b0; #1;
    checks++; if (imem_addr !== 32'h0000_0200 || imem_req !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL prio_jmp: got addr=%h req=%b v=%b expected 00000200 1 0", imem_addr, imem_req, out_valid); end
  endtask

  task automatic test_wrap();
    fixed = 32'hFFFF_FFFC; jmp = 1'b1;
    tick(); jmp = 1'b0; #1;
    checks++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin failures++; $display("FAIL wrap_tgt: got addr=%h req=%b expected fffffffc 1", imem_addr, imem_req); end
    tick();
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL wrap_next: got addr=%h req=%b expected 00000000 1", imem_addr, imem_req); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_instr !== mem_word(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_out0: got v=%b pc=%h i=%h expected 1 fffffffc %h", out_valid, out_pc, out_instr, mem_word(32'hFFFF_FFFC)); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== mem_word(32'h0)) begin failures++; $display("FAIL wrap_out1: got v=%b pc=%h i=%h expected 1 00000000 %h", out_valid, out_pc, out_instr, mem_word(32'h0)); end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    do_reset(1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k >= 1) begin
        checks++; if (out_valid !== 1'b1 || out_pc !== BASE) begin failures++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h expected 1 %h", k, out_valid, out_pc, BASE); end
      end
    end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req: got %b expected 0", imem_req); end
    checks++; if (n_acc !== 4) begin failures++; $display("FAIL stall_accepted: got %0d expected 4", n_acc); end
    out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      e = BASE + 32'(4 * j);
      checks++; if (out_valid !== 1'b1 || out_pc !== e || out_instr !== mem_word(e)) begin failures++; $display("FAIL stall_drain[%0d]: got v=%b pc=%h i=%h expected 1 %h %h", j, out_valid, out_pc, out_instr, e, mem_word(e)); end
      if (j == 1) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== BASE + 32'h10) begin failures++; $display("FAIL stall_resume: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, BASE + 32'h10); end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(3, 1'b1);
    repeat (3) tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== BASE + 32'hC) begin failures++; $display("FAIL redir_pre: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, BASE + 32'hC); end
    sign = 32'h0000_0100; br = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_req_held: got %b expected 0", imem_req); end
    tick(); br = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100 || out_valid !== 1'b0) begin failures++; $display("FAIL redir_tgt: got req=%b addr=%h v=%b expected 1 00000100 0", imem_req, imem_addr, out_valid); end
    for (int k = 4; k <= 6; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_stale[%0d]: got v=%b pc=%h expected v=0", k, out_valid, out_pc); end
    end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_0100 || out_instr !== mem_word(32'h100)) begin failures++; $display("FAIL redir_out: got v=%b pc=%h i=%h expected 1 00000100 %h", out_valid, out_pc, out_instr, mem_word(32'h100)); end
  endtask

  task automatic test_reset_mid();
    do_reset(3, 1'b0);
    repeat (5) tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== BASE) begin failures++; $display("FAIL rmid_pre: got v=%b pc=%h expected 1 %h", out_valid, out_pc, BASE); end
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin failures++; $display("FAIL rmid_clear: got v=%b req=%b pc=%h i=%h expected 0 0 0 0", out_valid, imem_req, out_pc, out_instr); end
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== BASE) begin failures++; $display("FAIL rmid_first: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, BASE); end
    for (int k = 6; k <= 8; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_empty[%0d]: got v=%b pc=%h expected v=0", k, out_valid, out_pc); end
    end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== BASE || out_instr !== mem_word(BASE)) begin failures++; $display("FAIL rmid_out: got v=%b pc=%h i=%h expected 1 %h %h", out_valid, out_pc, out_instr, BASE, mem_word(BASE)); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_seq();
    test_priority();
    test_wrap();
    test_stall();
    test_redirect();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
